// File: rtl/led_arb_pkg.sv
// led_arb_pkg: shared types and defaults for the LED bank arbiter.
//   state_t    - arbiter FSM state (IDLE, HOLD)
//   DEF_*      - default parameter values for led_arbiter
//   ptr_inc()  - round-robin pointer increment modulo n
package led_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int unsigned DEF_N_REQ       = 4;
   localparam int unsigned DEF_W           = 8;
   localparam int unsigned DEF_HOLD_CYCLES = 4;

   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/led_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search.
//   req   in  N_REQ  request vector
//   ptr   in  PW     highest-priority requester index
//   win   out N_REQ  one-hot winner (zero when no request)
//   valid out 1      any request present
module rr_picker #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned PW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] win,
   output logic             valid
);

   // Walk ptr, ptr+1, ... wrapping; the first asserted request wins.
   always_comb begin
      int unsigned idx;
      idx   = 0;
      win   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = (32'(ptr) + i) % N_REQ;
         if (!valid && req[idx[PW-1:0]]) begin
            win[idx[PW-1:0]] = 1'b1;
            valid            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/led_arbiter.sv
// led_arbiter: round-robin owner of the LED bank with a fixed hold time.
//   clk   in  1          system clock, rising edge
//   rstn  in  1          synchronous active-low reset
//   req   in  N_REQ      request per requester
//   data  in  N_REQ*W    requester i owns bits [i*W +: W]
//   led   out W          displayed pattern (snapshot at grant), registered
//   grant out N_REQ      one-hot owner, zero when idle, registered
//   busy  out 1          high while a grant is held, registered
module led_arbiter
   import led_arb_pkg::*;
#(
   parameter int unsigned N_REQ       = DEF_N_REQ,
   parameter int unsigned W           = DEF_W,
   parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] data,
   output logic [W-1:0]       led,
   output logic [N_REQ-1:0]   grant,
   output logic               busy
);

   localparam int unsigned PW = $clog2(N_REQ);
   localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [W-1:0]     led_q, led_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic             busy_q, busy_d;

   logic [N_REQ-1:0] win;
   logic             win_valid;
   logic [PW-1:0]    win_idx;
   logic             arb_en;

   rr_picker #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) u_picker (
      .req   (req),
      .ptr   (ptr_q),
      .win   (win),
      .valid (win_valid)
   );

   always_comb begin
      win_idx = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (win[i]) win_idx = PW'(i);
      end
   end

   // Arbitration happens when idle or on the last cycle of a hold, so a
   // persistent request is re-granted with no idle bubble.
   assign arb_en = (state_q == IDLE) || (cnt_q == '0);

   // State register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         led_q   <= '0;
         grant_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         led_q   <= led_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      led_d   = led_q;
      grant_d = grant_q;
      busy_d  = busy_q;
      if (arb_en) begin
         if (win_valid) begin
            state_d = HOLD;
            cnt_d   = CW'(HOLD_CYCLES - 1);
            ptr_d   = PW'(ptr_inc(32'(win_idx), N_REQ));
            led_d   = data[win_idx*W +: W];
            grant_d = win;
            busy_d  = 1'b1;
         end else begin
            state_d = IDLE;
            cnt_d   = '0;
            grant_d = '0;
            busy_d  = 1'b0;
         end
      end else begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Outputs
   always_comb begin
      led   = led_q;
      grant = grant_q;
      busy  = busy_q;
   end

endmodule
